spatz_spm_partition_ctrl: RTL and testbench



---
 rtl/spatz_spm_partition_ctrl.sv | 117 +++++++++++
 tb/tb_spatz_spm_partition_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_spm_partition_ctrl.sv
// spatz_spm_partition_ctrl: run-time SPM/cache split controller for the hybrid SRAM banks.
// Ports: cfg_* accepts a new SPM size (rows per bank) and optional zero-fill;
// done_o pulses on commit; spm_size_o drives the wrapper.
// cache_flush_req_o / cache_flush_done_i run the flush handshake, and
// cache_block_o / cache_busy_i quiesce the cache bank traffic.
// core_spm_* is the core SPM port, passed through to spm_* except while zero-filling.
module spatz_spm_partition_ctrl #(
   parameter int unsigned NumBanks      = 4,
   parameter int unsigned NumWords      = 512,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned ByteWidth     = 8,
   parameter int unsigned ResetSpmSize  = 0,
   parameter int unsigned MemAddrWidth  = $clog2(NumWords),
   parameter int unsigned BankAddrWidth = MemAddrWidth - $clog2(NumBanks),
   parameter int unsigned BeWidth       = DataWidth / ByteWidth
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cfg_valid_i,
   output logic                     cfg_ready_o,
   input  logic [BankAddrWidth-1:0] cfg_spm_size_i,
   input  logic                     cfg_clear_i,
   output logic                     done_o,
   output logic [BankAddrWidth-1:0] spm_size_o,
   output logic                     cache_flush_req_o,
   input  logic                     cache_flush_done_i,
   output logic                     cache_block_o,
   input  logic [NumBanks-1:0]      cache_busy_i,
   input  logic                     core_spm_req_i,
   input  logic                     core_spm_we_i,
   input  logic [MemAddrWidth-1:0]  core_spm_addr_i,
   input  logic [DataWidth-1:0]     core_spm_wdata_i,
   input  logic [BeWidth-1:0]       core_spm_be_i,
   output logic                     core_spm_gnt_o,
   output logic                     spm_req_o,
   output logic                     spm_we_o,
   output logic [MemAddrWidth-1:0]  spm_addr_o,
   output logic [DataWidth-1:0]     spm_wdata_o,
   output logic [BeWidth-1:0]       spm_be_o
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FLUSH  = 3'd1;
   localparam logic [2:0] DRAIN  = 3'd2;
   localparam logic [2:0] INIT   = 3'd3;
   localparam logic [2:0] COMMIT = 3'd4;

   localparam logic [MemAddrWidth:0] Nb  = (MemAddrWidth+1)'(NumBanks);
   localparam logic [MemAddrWidth:0] One = (MemAddrWidth+1)'(1);

   logic [2:0]               state;
   logic [BankAddrWidth-1:0] new_size, old_size;
   logic                     clear;
   // one extra bit so the largest size cannot wrap the fill counter
   logic [MemAddrWidth:0]    cnt;
   logic [MemAddrWidth:0]    last;
   logic                     in_init;

   assign last    = (MemAddrWidth+1)'(new_size) * Nb - One;
   assign in_init = state == INIT;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         spm_size_o <= BankAddrWidth'(ResetSpmSize);
         new_size   <= '0;
         old_size   <= '0;
         clear      <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: if (cfg_valid_i) begin
               new_size <= cfg_spm_size_i;
               clear    <= cfg_clear_i;
               old_size <= spm_size_o;
               if (cfg_spm_size_i == spm_size_o) begin
                  state      <= COMMIT;
                  spm_size_o <= cfg_spm_size_i;
               end else begin
                  state <= FLUSH;
               end
            end
            FLUSH: if (cache_flush_done_i) state <= DRAIN;
            DRAIN: if (cache_busy_i == '0) begin
               if (clear && new_size > old_size) begin
                  state <= INIT;
                  cnt   <= (MemAddrWidth+1)'(old_size) * Nb;
               end else begin
                  state      <= COMMIT;
                  spm_size_o <= new_size;
               end
            end
            INIT: if (cnt == last) begin
               state      <= COMMIT;
               spm_size_o <= new_size;
            end else begin
               cnt <= cnt + One;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      cfg_ready_o       = state == IDLE && !rst_i;
      done_o            = state == COMMIT;
      cache_flush_req_o = state == FLUSH;
      cache_block_o     = state == DRAIN || in_init || state == COMMIT;
      core_spm_gnt_o    = core_spm_req_i && !in_init;
      spm_req_o         = in_init ? 1'b1 : core_spm_req_i;
      spm_we_o          = in_init ? 1'b1 : core_spm_we_i;
      spm_addr_o        = in_init ? cnt[MemAddrWidth-1:0] : core_spm_addr_i;
      spm_wdata_o       = in_init ? '0 : core_spm_wdata_i;
      spm_be_o          = in_init ? '1 : core_spm_be_i;
   end

endmodule

// File: tb/tb_spatz_spm_partition_ctrl.sv
// tb_spatz_spm_partition_ctrl: directed self-checking bench for spatz_spm_partition_ctrl.
module tb_spatz_spm_partition_ctrl;

   localparam int MAW = 9;
   localparam int BAW = 7;
   localparam int DW  = 32;
   localparam int BEW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           cfg_valid, cfg_ready, cfg_clear, done;
   logic [BAW-1:0] cfg_size, spm_size;
   logic           flush_req, flush_done, block;
   logic [3:0]     busy;
   logic           core_req, core_we, core_gnt;
   logic [MAW-1:0] core_addr, spm_addr;
   logic [DW-1:0]  core_wdata, spm_wdata;
   logic [BEW-1:0] core_be, spm_be;
   logic           spm_req, spm_we;

   int checks = 0;
   int errors = 0;

   spatz_spm_partition_ctrl dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .cfg_valid_i        (cfg_valid),
      .cfg_ready_o        (cfg_ready),
      .cfg_spm_size_i     (cfg_size),
      .cfg_clear_i        (cfg_clear),
      .done_o             (done),
      .spm_size_o         (spm_size),
      .cache_flush_req_o  (flush_req),
      .cache_flush_done_i (flush_done),
      .cache_block_o      (block),
      .cache_busy_i       (busy),
      .core_spm_req_i     (core_req),
      .core_spm_we_i      (core_we),
      .core_spm_addr_i    (core_addr),
      .core_spm_wdata_i   (core_wdata),
      .core_spm_be_i      (core_be),
      .core_spm_gnt_o     (core_gnt),
      .spm_req_o          (spm_req),
      .spm_we_o           (spm_we),
      .spm_addr_o         (spm_addr),
      .spm_wdata_o        (spm_wdata),
      .spm_be_o           (spm_be)
   );

   always #5 clk = ~clk;

   task automatic nxt;
      @(negedge clk);
   endtask

   task automatic accept(input logic [BAW-1:0] sz, input logic clr);
      nxt;
      cfg_valid = 1'b1;
      cfg_size  = sz;
      cfg_clear = clr;
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got %b exp 1", cfg_ready); end
      nxt;
      cfg_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; cfg_valid = 0; cfg_size = 0; cfg_clear = 0; flush_done = 0; busy = 0;
      core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_be = 0;
      nxt;
      #1;
      checks++;
      if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_in_reset got %b exp 0", cfg_ready); end
      nxt;
      rst = 1'b0;
      #1;
      checks++;
      if (spm_size !== 7'h00) begin errors++; $display("FAIL reset_size got %h exp 00", spm_size); end
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
      checks++;
      if ({done, flush_req, block, spm_req} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {done, flush_req, block, spm_req}); end
      core_req = 1; core_we = 1; core_addr = 9'h012; core_wdata = 32'hdeadbeef; core_be = 4'h3;
      #1;
      checks++;
      if ({spm_req, spm_we, core_gnt} !== 3'b111) begin errors++; $display("FAIL pass_req got %b exp 111", {spm_req, spm_we, core_gnt}); end
      checks++;
      if (spm_addr !== 9'h012) begin errors++; $display("FAIL pass_addr got %h exp 012", spm_addr); end
      checks++;
      if ({spm_wdata, spm_be} !== {32'hdeadbeef, 4'h3}) begin errors++; $display("FAIL pass_data got %h/%h exp deadbeef/3", spm_wdata, spm_be); end
      core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_be = 0;
   endtask

   task automatic test_setup_grow;
      accept(7'h10, 1'b0);
      checks++;
      if ({flush_req, block, cfg_ready} !== 3'b100) begin errors++; $display("FAIL setup_flush got %b exp 100", {flush_req, block, cfg_ready}); end
      flush_done = 1'b1;
      nxt;
      flush_done = 1'b0;
      #1;
      checks++;
      if ({flush_req, block} !== 2'b01) begin errors++; $display("FAIL setup_drain got %b exp 01", {flush_req, block}); end
      nxt;
      #1;
      checks++;
      if ({done, spm_req, spm_size} !== {2'b10, 7'h10}) begin errors++; $display("FAIL setup_commit got %b/%b/%h exp 1/0/10", done, spm_req, spm_size); end
      nxt;
      #1;
      checks++;
      if ({done, cfg_ready} !== 2'b01) begin errors++; $display("FAIL setup_idle got %b exp 01", {done, cfg_ready}); end
   endtask

   task automatic test_grow_clear;
      busy = 4'b0101;
      accept(7'h14, 1'b1);
      for (int i = 2; i <= 5; i++) begin
         nxt;
         if (i == 5) flush_done = 1'b1;
         #1;
         checks++;
         if (flush_req !== 1'b1) begin errors++; $display("FAIL grow_flush%0d got %b exp 1", i, flush_req); end
      end
      nxt;
      flush_done = 1'b0;
      #1;
      checks++;
      if ({flush_req, block} !== 2'b01) begin errors++; $display("FAIL grow_drain1 got %b exp 01", {flush_req, block}); end
      nxt;
      #1;
      checks++;
      if ({block, spm_req} !== 2'b10) begin errors++; $display("FAIL grow_drain2 got %b exp 10", {block, spm_req}); end
      nxt;
      busy = 4'b0000;
      core_req = 1; core_addr = 9'h1AB; core_wdata = 32'h12345678; core_be = 4'h1;
      #1;
      checks++;
      if ({block, core_gnt, spm_addr} !== {2'b11, 9'h1AB}) begin errors++; $display("FAIL grow_drain3 got %b/%b/%h exp 1/1/1ab", block, core_gnt, spm_addr); end
      for (int i = 0; i < 16; i++) begin
         nxt;
         #1;
         checks++;
         if ({spm_req, spm_we, core_gnt, block, done} !== 5'b11010) begin errors++; $display("FAIL init_ctrl%0d got %b exp 11010", i, {spm_req, spm_we, core_gnt, block, done}); end
         checks++;
         if (spm_addr !== 9'(9'h040 + i)) begin errors++; $display("FAIL init_addr%0d got %h exp %h", i, spm_addr, 9'(9'h040 + i)); end
         checks++;
         if ({spm_wdata, spm_be} !== {32'h0, 4'hF}) begin errors++; $display("FAIL init_data%0d got %h/%h exp 0/f", i, spm_wdata, spm_be); end
      end
      nxt;
      #1;
      checks++;
      if ({done, spm_size} !== {1'b1, 7'h14}) begin errors++; $display("FAIL grow_commit got %b/%h exp 1/14", done, spm_size); end
      checks++;
      if ({core_gnt, spm_we, spm_addr} !== {2'b10, 9'h1AB}) begin errors++; $display("FAIL grow_commit_gnt got %b/%b/%h exp 1/0/1ab", core_gnt, spm_we, spm_addr); end
      core_req = 0; core_addr = 0; core_wdata = 0; core_be = 0;
      nxt;
      #1;
      checks++;
      if ({done, cfg_ready, spm_req, block} !== 4'b0100) begin errors++; $display("FAIL grow_idle got %b exp 0100", {done, cfg_ready, spm_req, block}); end
   endtask

   task automatic test_shrink;
      accept(7'h08, 1'b1);
      checks++;
      if (flush_req !== 1'b1) begin errors++; $display("FAIL shrink_flush got %b exp 1", flush_req); end
      flush_done = 1'b1;
      nxt;
      flush_done = 1'b0;
      #1;
      checks++;
      if ({block, spm_req} !== 2'b10) begin errors++; $display("FAIL shrink_drain got %b exp 10", {block, spm_req}); end
      nxt;
      #1;
      checks++;
      if ({done, spm_req, spm_size} !== {2'b10, 7'h08}) begin errors++; $display("FAIL shrink_commit got %b/%b/%h exp 1/0/08", done, spm_req, spm_size); end
   endtask

   task automatic test_same_size;
      accept(7'h08, 1'b0);
      checks++;
      if ({done, flush_req, cfg_ready, spm_size} !== {3'b100, 7'h08}) begin errors++; $display("FAIL same_commit got %b/%b/%b/%h exp 1/0/0/08", done, flush_req, cfg_ready, spm_size); end
      nxt;
      #1;
      checks++;
      if ({done, cfg_ready, flush_req} !== 3'b010) begin errors++; $display("FAIL same_idle got %b exp 010", {done, cfg_ready, flush_req}); end
   endtask

   task automatic test_reset_mid_init;
      accept(7'h0C, 1'b1);
      flush_done = 1'b1;
      nxt;
      flush_done = 1'b0;
      #1;
      checks++;
      if (block !== 1'b1) begin errors++; $display("FAIL rmi_drain got %b exp 1", block); end
      for (int i = 0; i < 5; i++) begin
         nxt;
         #1;
         checks++;
         if ({spm_req, spm_addr} !== {1'b1, 9'(9'h020 + i)}) begin errors++; $display("FAIL rmi_addr%0d got %b/%h exp 1/%h", i, spm_req, spm_addr, 9'(9'h020 + i)); end
         if (i == 4) rst = 1'b1;
      end
      nxt;
      rst = 1'b0;
      #1;
      checks++;
      if ({cfg_ready, spm_req, block, done, spm_size} !== {4'b1000, 7'h00}) begin errors++; $display("FAIL rmi_idle got %b/%b/%b/%b/%h exp 1/0/0/0/00", cfg_ready, spm_req, block, done, spm_size); end
      for (int i = 0; i < 3; i++) begin
         nxt;
         #1;
         checks++;
         if ({spm_req, done} !== 2'b00) begin errors++; $display("FAIL rmi_quiet%0d got %b exp 00", i, {spm_req, done}); end
      end
   endtask

   initial begin
      test_reset;
      test_setup_grow;
      test_grow_clear;
      test_shrink;
      test_same_size;
      test_reset_mid_init;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
